sync_fifo_core: RTL and testbench
=================================

// Module: sync_fifo_core
// PURPOSE
//   Single-clock FIFO: the storage/responder end of the wr_en/rd_en
//   fill-and-drain interface used by our FIFO test FSMs. Replaces the
//   vendor FIFO IP with portable RTL and keeps the same port semantics.
//   Adds status flags, occupancy counts, and overflow/underflow pulses
//   for ILA probing.
// PARAMETERS
//   DATA_W     16   data width in bits
//   ADDR_W     8    address width; DEPTH = 2**ADDR_W = 256 entries
//   AF_LEVEL   254  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL   2    almost_empty asserts when count <= AE_LEVEL
// PORTS
//   clk            in   1         system clock (50 MHz)
//   rst_n          in   1         reset, asynchronous, active-low
//   din            in   DATA_W    write data
//   wr_en          in   1         write request
//   rd_en          in   1         read request
//   dout           out  DATA_W    read data, registered
//   valid          out  1         dout updated by an accepted read this cycle
//   wr_ack         out  1         previous-cycle write accepted
//   full           out  1         count == DEPTH
//   empty          out  1         count == 0
//   almost_full    out  1         count >= AF_LEVEL
//   almost_empty   out  1         count <= AE_LEVEL
//   overflow       out  1         previous-cycle write rejected (full)
//   underflow      out  1         previous-cycle read rejected (empty)
//   wr_data_count  out  ADDR_W+1  occupancy, 0..DEPTH
//   rd_data_count  out  ADDR_W+1  occupancy, 0..DEPTH (same value)
// BEHAVIOUR
//   - Reset (async assert, sync release): wr_ptr = rd_ptr = count = 0.
//     dout = 0. empty = 1, almost_empty = 1. All other outputs 0.
//     Memory array contents are not cleared. Reset mid-transfer discards
//     all stored words.
//   - Pointers are ADDR_W+1 bits. Address = low ADDR_W bits. Pointers wrap
//     naturally at 2**(ADDR_W+1). count = wr_ptr - rd_ptr, held in a register.
//   - Accept rules use flags as they stand before the clock edge:
//     wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty.
//   - Write: on wr_acc, mem[wr_ptr] <= din and wr_ptr++. wr_ack = 1 for the
//     next cycle.
//   - Read latency is 1 cycle. On rd_acc, dout <= mem[rd_ptr] and rd_ptr++.
//     valid = 1 in the cycle dout shows the new word. Otherwise dout holds.
//     No first-word fall-through.
//   - Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on
//     both or neither.
//   - Flags are registered and computed from the next count, so they are
//     exact on the same edge the count changes.
//   - Full + wr_en + rd_en: read accepted, write rejected. overflow pulses,
//     count goes DEPTH-1, full drops.
//   - Empty + wr_en + rd_en: write accepted, read rejected. underflow
//     pulses, count goes 1, empty drops. dout is unchanged.
//   - Not full, not empty, both asserted: both accepted, count unchanged.
//     Reading the same address as a concurrent write is impossible when
//     count > 0.
//   - overflow and underflow are single-cycle pulses, one per rejected
//     request. The FIFO state is never altered by a rejected request.
//   - The memory is written synchronously with no reset so it infers
//     block RAM. The read port is registered.
// TESTING
//   1 Reset release -> empty=1, full=0, counts=0, dout=0, valid=0.
//   2 Write 256 words din=0..255 with rd_en=0 -> full=1 on the edge of the
//     256th write, counts=256, almost_full from count 254. A 257th write
//     gives overflow=1 for 1 cycle and counts stay 256.
//   3 From full, rd_en=1 for 256 cycles -> dout=0..255 in order, each word
//     1 cycle after its rd_en with valid=1. empty=1 after the last read. An
//     extra read gives underflow=1 and dout holds 255.
//   4 Count=100 with wr_en=rd_en=1 for 50 cycles -> counts stay 100, data
//     order preserved across pointer wrap (start wr_ptr at 230).
//   5 Full with wr_en=rd_en=1 -> count 255, overflow=1, full=0.
//     Empty with both asserted -> count 1, underflow=1, valid=0.
//   6 rst_n low mid-fill at count=37 -> outputs return to reset values
//     immediately. The next write/read pair returns the new word, not stale
//     data.

Source files
------------

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with registered read port, status flags, occupancy counts
// and overflow/underflow pulses. Flags are derived from the next occupancy.
module sync_fifo_core #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int AF_LEVEL = 254,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              wr_ack,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    output logic [ADDR_W:0]   wr_data_count,
    output logic [ADDR_W:0]   rd_data_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

    // Handshake: a request is taken on the clock edge where it is high and the
    // flag it depends on (full for writes, empty for reads) is low before that
    // edge; a request that is not taken leaves all FIFO state untouched.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q, wr_ack_q, overflow_q, underflow_q;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              wr_acc, rd_acc;

    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (rd_acc) dout_q <= mem[rd_ptr_q[ADDR_W-1:0]];
            valid_q     <= rd_acc;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en & full_q;
            underflow_q <= rd_en & empty_q;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
        end
    end

    assign dout          = dout_q;
    assign valid         = valid_q;
    assign wr_ack        = wr_ack_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign almost_full   = af_q;
    assign almost_empty  = ae_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;
    assign wr_data_count = count_q;
    assign rd_data_count = count_q;
endmodule

// File: tb/tb_sync_fifo_core.sv
// Randomised bench for sync_fifo_core: a queue-based reference model feeds an
// expected-read queue that an independent monitor drains and compares.
module tb_sync_fifo_core;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              valid, wr_ack, full, empty, almost_full, almost_empty;
    logic              overflow, underflow;
    logic [ADDR_W:0]   wr_data_count, rd_data_count;

    sync_fifo_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(254), .AE_LEVEL(2)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .valid(valid), .wr_ack(wr_ack), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow),
        .wr_data_count(wr_data_count), .rd_data_count(rd_data_count)
    );

    always #10 clk = ~clk;

    // Reference model: stored words, expected read data, expected pulses.
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_dout = '0;
    bit exp_wr_ack = 0, exp_ovf = 0, exp_udf = 0;
    int checks = 0, errors = 0;

    function automatic void check(string name, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endfunction

    // One clock of stimulus; the model advances on the same edge as the DUT.
    task automatic step(input bit w, input bit r, input logic [DATA_W-1:0] d);
        bit is_full, is_empty, wa, ra;
        @(negedge clk);
        wr_en = w; rd_en = r; din = d;
        is_full  = (model_q.size() == DEPTH);
        is_empty = (model_q.size() == 0);
        wa = w && !is_full;
        ra = r && !is_empty;
        @(posedge clk);
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        exp_wr_ack = wa;
        exp_ovf    = w && is_full;
        exp_udf    = r && is_empty;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        wr_en = 0; rd_en = 0; din = '0;
        rst_n = 0;
        model_q.delete(); exp_q.delete();
        exp_dout = '0; exp_wr_ack = 0; exp_ovf = 0; exp_udf = 0;
        #1;
        check("rst_dout", dout, 0);
        check("rst_valid", valid, 0);
        check("rst_empty", empty, 1);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_wr_count", wr_data_count, 0);
        check("rst_rd_count", rd_data_count, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: compares every output one step after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                check("valid", valid, int'(exp_q.size() != 0));
                if (exp_q.size() != 0) exp_dout = exp_q.pop_front();
                check("dout", dout, exp_dout);
                check("wr_data_count", wr_data_count, model_q.size());
                check("rd_data_count", rd_data_count, model_q.size());
                check("full", full, int'(model_q.size() == DEPTH));
                check("empty", empty, int'(model_q.size() == 0));
                check("almost_full", almost_full, int'(model_q.size() >= 254));
                check("almost_empty", almost_empty, int'(model_q.size() <= 2));
                check("wr_ack", wr_ack, exp_wr_ack);
                check("overflow", overflow, exp_ovf);
                check("underflow", underflow, exp_udf);
            end
        end
    end

    initial begin
        // Reset state, then idle cycles
        apply_reset();
        repeat (2) step(0, 0, '0);

        // Fill to full, then one extra write
        for (int i = 0; i < DEPTH; i++) step(1, 0, DATA_W'(i));
        step(1, 0, 16'hdead);
        step(0, 0, '0);

        // Drain in order, then one extra read
        for (int i = 0; i < DEPTH; i++) step(0, 1, '0);
        step(0, 1, '0);
        step(0, 0, '0);

        // Move pointers to 230 with count 100, then simultaneous traffic across wrap
        apply_reset();
        for (int i = 0; i < 130; i++) step(1, 0, DATA_W'($urandom_range(0, 65535)));
        for (int i = 0; i < 130; i++) step(0, 1, '0);
        for (int i = 0; i < 100; i++) step(1, 0, DATA_W'($urandom_range(0, 65535)));
        for (int i = 0; i < 50; i++) step(1, 1, DATA_W'($urandom_range(0, 65535)));

        // Full with both requests, then empty with both requests
        while (model_q.size() < DEPTH) step(1, 0, DATA_W'($urandom_range(0, 65535)));
        step(1, 1, 16'h1234);
        step(0, 0, '0);
        while (model_q.size() > 0) step(0, 1, '0);
        step(1, 1, 16'h5678);
        step(0, 0, '0);
        step(0, 1, '0);

        // Random mixed traffic
        for (int i = 0; i < 400; i++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 DATA_W'($urandom_range(0, 65535)));

        // Reset mid-fill at 37, then a fresh word must come back
        apply_reset();
        for (int i = 0; i < 37; i++) step(1, 0, DATA_W'(16'h0100 + i));
        apply_reset();
        step(1, 0, 16'hbeef);
        step(0, 1, '0);
        repeat (3) step(0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
